// File: rtl/full_adder_pkg.sv
// ----------------------------------------------------------------------------
// full_adder_pkg
// Purpose : Shared constants for the registered ripple-carry adder.
// Contents: FA_WIDTH_DEFAULT - default operand width (1 bit)
//           FA_WIDTH_MAX     - largest legal operand width (64 bits)
// ----------------------------------------------------------------------------
package full_adder_pkg;

    localparam int FA_WIDTH_DEFAULT = 1;
    localparam int FA_WIDTH_MAX     = 64;

endpackage : full_adder_pkg

// File: rtl/full_adder_cell.sv
// ----------------------------------------------------------------------------
// full_adder_cell
// Purpose : One-bit combinational full adder, the link of the ripple chain.
// Ports   : a, b  - addend bits
//           cin   - carry into this bit
//           s     - sum bit, a ^ b ^ cin
//           cout  - carry out of this bit, majority(a, b, cin)
// ----------------------------------------------------------------------------
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic half_sum;

    assign half_sum = a ^ b;
    assign s        = half_sum ^ cin;
    // Generate when both addends are set, propagate cin when exactly one is.
    assign cout     = (a & b) | (cin & half_sum);

endmodule : full_adder_cell

// File: rtl/full_adder.sv
// ----------------------------------------------------------------------------
// full_adder
// Purpose : WIDTH-bit unsigned ripple-carry adder with a single output
//           register stage. {cout, s} = a + b + cin, one cycle after the
//           operands are sampled; a new operand set is accepted every cycle.
// Params  : WIDTH - operand width, 1..64
// Ports   : clk   - rising-edge clock
//           rst   - synchronous, active-high reset; clears s and cout
//           a, b  - unsigned addends, WIDTH bits
//           cin   - carry-in, weight 1
//           s     - registered sum, bits [WIDTH-1:0] of a + b + cin
//           cout  - registered carry-out, bit WIDTH of a + b + cin
// ----------------------------------------------------------------------------
module full_adder
    import full_adder_pkg::*;
#(
    parameter int WIDTH = FA_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             cout
);

    // Refuse to elaborate for widths outside the supported range.
    if (WIDTH < 1 || WIDTH > FA_WIDTH_MAX) begin : g_width_check
        $error("full_adder: WIDTH=%0d is outside the legal range 1..%0d",
               WIDTH, FA_WIDTH_MAX);
    end

    // carry[i] enters bit i; carry[WIDTH] leaves the top bit.
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_bits;

    logic [WIDTH-1:0] s_d;
    logic [WIDTH-1:0] s_q;
    logic             cout_d;
    logic             cout_q;

    assign carry[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        full_adder_cell u_cell (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (carry[i]),
            .s    (sum_bits[i]),
            .cout (carry[i+1])
        );
    end

    always_comb begin
        s_d    = sum_bits;
        cout_d = carry[WIDTH];
    end

    // Output register: the only state in the block, so reset leaves nothing
    // behind from a discarded operand set.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_q    <= '0;
            cout_q <= 1'b0;
        end else begin
            s_q    <= s_d;
            cout_q <= cout_d;
        end
    end

    assign s    = s_q;
    assign cout = cout_q;

endmodule : full_adder

// File: tb/tb_full_adder.sv
// ----------------------------------------------------------------------------
// tb_full_adder
// Purpose : Self-checking bench for full_adder at WIDTH = 1, 8 and 16.
//           Expected results come from plain integer addition of the applied
//           operands, one cycle behind the edge that sampled them.
// ----------------------------------------------------------------------------
module tb_full_adder;

    logic clk = 1'b0;
    logic rst;

    logic        a1, b1, c1;
    logic        s1, co1;
    logic [7:0]  a8, b8, s8;
    logic        c8, co8;
    logic [15:0] a16, b16, s16;
    logic        c16, co16;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    full_adder #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .cin(c1), .s(s1), .cout(co1)
    );
    full_adder #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .cin(c8), .s(s8), .cout(co8)
    );
    full_adder #(.WIDTH(16)) u_w16 (
        .clk(clk), .rst(rst), .a(a16), .b(b16), .cin(c16), .s(s16), .cout(co16)
    );

    task automatic check(input string tag, input logic [64:0] obs,
                         input logic [64:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected {cout,s} for WIDTH=1 combinations 000..111 (a,b,cin).
    logic [1:0]  exh_exp [8] = '{2'b00, 2'b01, 2'b01, 2'b10,
                                 2'b01, 2'b10, 2'b10, 2'b11};
    logic [2:0]  combo;
    logic [16:0] ref16;
    logic [8:0]  ref8;

    initial begin
        // Reset with all operands at ones: outputs must still clear.
        rst = 1'b1;
        a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
        a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1;
        a16 = 16'hFFFF; b16 = 16'hFFFF; c16 = 1'b1;
        for (int r = 0; r < 2; r++) begin
            tick();
            check($sformatf("reset_w1_%0d", r), {63'd0, co1, s1}, 65'd0);
            check($sformatf("reset_w8_%0d", r), {56'd0, co8, s8}, 65'd0);
            check($sformatf("reset_w16_%0d", r), {48'd0, co16, s16}, 65'd0);
        end

        // Exhaustive WIDTH=1; after each check, the next operands are applied
        // and the output must not move until the following edge.
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            combo = 3'(i);
            {a1, b1, c1} = combo;
            tick();
            check($sformatf("exh_%0d", i), {63'd0, co1, s1}, {63'd0, exh_exp[i]});
            combo = 3'(i + 3);
            {a1, b1, c1} = combo;
            #3;
            check($sformatf("hold_%0d", i), {63'd0, co1, s1}, {63'd0, exh_exp[i]});
        end

        // Reset mid-stream: the carry result pending at the reset edge is lost.
        a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
        tick();
        check("pre_mid_rst", {63'd0, co1, s1}, 65'd3);
        a1 = 1'b1; b1 = 1'b1; c1 = 1'b0;
        rst = 1'b1;
        tick();
        check("mid_rst", {63'd0, co1, s1}, 65'd0);
        rst = 1'b0;
        tick();
        check("post_mid_rst", {63'd0, co1, s1}, 65'd2);

        // WIDTH=8 directed: full ripple, overflow, then back-to-back operands.
        a8 = 8'hFF; b8 = 8'h00; c8 = 1'b1;
        tick();
        check("w8_ripple", {56'd0, co8, s8}, 65'h100);
        a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1;
        tick();
        check("w8_overflow", {56'd0, co8, s8}, 65'h1FF);
        a8 = 8'h3C; b8 = 8'h05; c8 = 1'b0;
        tick();
        check("w8_b2b", {56'd0, co8, s8}, 65'h041);
        a8 = 8'h00; b8 = 8'h00; c8 = 1'b0;
        tick();
        check("w8_zero", {56'd0, co8, s8}, 65'h000);
        for (int i = 0; i < 16; i++) begin
            a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom_range(0, 1));
            ref8 = 9'(a8) + 9'(b8) + 9'(c8);
            tick();
            check($sformatf("w8_rand_%0d", i), {56'd0, co8, s8}, {56'd0, ref8});
        end

        // Unknown operands for one cycle must not disturb the next result.
        a16 = 'x; b16 = 'x; c16 = 1'bx;
        tick();
        a16 = 16'h1234; b16 = 16'hEDCB; c16 = 1'b1;
        tick();
        check("w16_after_x", {48'd0, co16, s16}, 65'h10000);

        // WIDTH=16 random, one vector per cycle.
        for (int i = 0; i < 10000; i++) begin
            a16 = 16'($urandom);
            b16 = 16'($urandom);
            c16 = 1'($urandom_range(0, 1));
            ref16 = 17'(a16) + 17'(b16) + 17'(c16);
            tick();
            check("w16_rand", {48'd0, co16, s16}, {48'd0, ref16});
        end

        // Extremes at WIDTH=16.
        a16 = 16'hFFFF; b16 = 16'hFFFF; c16 = 1'b1;
        tick();
        check("w16_overflow", {48'd0, co16, s16}, 65'h1FFFF);
        a16 = 16'h0000; b16 = 16'h0000; c16 = 1'b0;
        tick();
        check("w16_zero", {48'd0, co16, s16}, 65'h00000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_full_adder

// File: doc/full_adder.md
FULL_ADDER -- requirements
Module: full_adder

Interface
REQ-001 Parameter: WIDTH, default 1, operand width in bits; legal range 1..64.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst  input  1  reset; synchronous, active-high.
REQ-004 Port: a  input  WIDTH  addend A, unsigned.
REQ-005 Port: b  input  WIDTH  addend B, unsigned.
REQ-006 Port: cin  input  1  carry-in, weight 1.
REQ-007 Port: s  output  WIDTH  registered sum, bits [WIDTH-1:0] of a+b+cin.
REQ-008 Port: cout  output  1  registered carry-out, bit WIDTH of a+b+cin.
REQ-009 The block SHALL have exactly one clock, clk; its reset, rst, SHALL be synchronous and active-high.

Function
REQ-010 On each rising clk edge with rst=0, the block SHALL capture {cout,s} = a + b + cin, computed at WIDTH+1 bits with no truncation before the register.
REQ-011 Latency SHALL be exactly 1 cycle: inputs sampled at edge N SHALL appear on s/cout after edge N, and hold until edge N+1.
REQ-012 Outputs SHALL come straight from flops, with no combinational path from any input to s or cout.
REQ-013 For WIDTH=1: s = a XOR b XOR cin; cout = majority(a,b,cin) = (a AND b) OR (cin AND (a XOR b)).
REQ-014 For WIDTH>1, the carry SHALL ripple from bit 0 to bit WIDTH-1; cin feeds bit 0; cout is the carry out of bit WIDTH-1.
REQ-015 Overflow case: a = b = all-ones with cin=1 SHALL give s = all-ones and cout=1.
REQ-016 Zero case: a = b = 0 with cin=0 SHALL give s=0 and cout=0.
REQ-017 No handshake: the block SHALL accept new operands every cycle, with throughput 1 result per cycle.
REQ-018 Inputs that change between edges SHALL have no effect until the next rising edge.
REQ-019 X/Z on any input SHALL not corrupt a later cycle once the inputs are driven to known values.

Reset
REQ-020 While rst=1 at a rising edge, s SHALL load all-zeros and cout SHALL load 0, regardless of a, b and cin.
REQ-021 Reset SHALL take priority over the addition on the same edge.
REQ-022 On the first edge with rst=0 after reset, the block SHALL register the sum of the inputs present at that edge.
REQ-023 Reset asserted mid-stream SHALL discard the pending result with no residual state; the block holds no state other than s and cout.
REQ-024 Before the first clk edge, the output value is unspecified; the bench SHALL apply reset for at least 1 cycle.

Structure
REQ-025 A shared package full_adder_pkg SHALL hold only the WIDTH default constant (1) and the maximum legal WIDTH (64); no typedefs are required.
REQ-026 One sub-module full_adder_cell (1-bit combinational: a, b, cin -> s, cout) SHALL be instantiated WIDTH times in a generate loop, forming the ripple chain.
REQ-027 The top level SHALL contain the generate loop, the carry chain wiring and the output register stage only.
REQ-028 The top level SHALL elaborate-time check that WIDTH lies in 1..64 and SHALL fail elaboration otherwise.

Verification
REQ-029 Reset: rst=1 for 2 cycles with a=1, b=1, cin=1 -> s=0 and cout=0 after each reset edge.
REQ-030 Exhaustive WIDTH=1: apply all 8 combinations of (a,b,cin) in order 000..111, each held for at least 1 cycle -> {cout,s} = 00,01,01,10,01,10,10,11, each 1 cycle after its apply edge.
REQ-031 WIDTH=8, a=8'hFF, b=8'h00, cin=1 -> s=8'h00, cout=1 (full carry ripple).
REQ-032 WIDTH=8, a=8'hFF, b=8'hFF, cin=1 -> s=8'hFF, cout=1; then a=8'h3C, b=8'h05, cin=0 on the next cycle -> s=8'h41, cout=0 (back-to-back throughput).
REQ-033 Reset mid-stream: WIDTH=1, a=1, b=1, cin=0 at edge N with rst=1 at edge N -> s=0 and cout=0, not the carry result; rst=0 at edge N+1 -> s=0, cout=1.
REQ-034 Random: WIDTH=16, 10,000 random (a,b,cin) vectors, one per cycle -> {cout,s} matches the WIDTH+1-bit reference sum, delayed 1 cycle.
